basis_list_sequencer: RTL and testbench
=======================================

# basis_list_sequencer

Command-driven controller for the basis-index list datapath in the stabilizer gate engine. It accepts one gate command per pass, latches the normalized gate type and qubit positions, and drives exactly 2**num_qubit rotate strobes so every entry of basis list 2 is rotated and refreshed once. A done pulse closes each pass. The gate-level scheduler sits upstream; the basis-index list block sits downstream.

## Interface
- num_qubit, 4, number of qubits; list depth is 2**num_qubit
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_gate_type  in  3  0 Hadamard, 1 Phase, 2 CNOT, 3 Measurement, 4 Controlled Phase-Shift, 5 Toffoli
- cmd_qubit_pos  in  32  primary qubit / control
- cmd_qubit_pos2  in  32  target qubit (CNOT/Toffoli)
- cmd_qubit_pos_ahead  in  32  qubit of the following gate
- cmd_reload  in  1  1: refill from list 1; 0: refresh-rotate only
- stall  in  1  freeze pass (present only with BASIS_SEQ_STALL_EN)
- gate_type_norm  out  3  latched gate type
- qubit_pos_norm, qubit_pos2_norm, qubit_pos_ahead  out  32 each  latched positions
- ld_basis_index_in  out  1  rotate strobe, reload mode
- rotateLeft_stabilizer_basis2  out  1  rotate strobe, refresh mode
- busy  out  1  pass in progress
- done  out  1  one-cycle end-of-pass pulse
- err  out  1  one-cycle pulse, with done, for a rejected command

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: cmd_ready=1. When cmd_valid is high, the command is accepted and all cmd_* fields are latched into the *_norm / ahead registers and a mode flag.
- Range check at accept: gate_type>5, qubit_pos≥num_qubit, qubit_pos_ahead≥num_qubit, or (type 2/5 and qubit_pos2≥num_qubit, or qubit_pos2==qubit_pos) marks the command bad. A bad command goes straight to DONE with err=1 and issues no strobes.
- RUN: one strobe per non-stalled cycle. ld_basis_index_in is used when mode=reload; otherwise rotateLeft_stabilizer_basis2. The two strobes are never high together.
- Pass counter is num_qubit+1 bits. It clears at accept and increments per strobe. After the strobe with count==2**num_qubit-1, go to DONE.
- DONE: done=1, cmd_ready=0. The next state is IDLE.
- busy=1 in RUN and DONE.
- Latched outputs hold their values until the next accept. They must stay stable for the whole pass.
- cmd_valid while not in IDLE is ignored. The command is not consumed.
- Reset mid-pass aborts immediately: all outputs return to reset values, no done is issued, and the FSM goes to IDLE.
- Reset values: cmd_ready=1 after release, all strobes/busy/done/err=0, gate_type_norm=0, all positions=0.

## Timing
- Accept at edge T. Latched outputs are valid and the first strobe is asserted in cycle T+1.
- Without stall, the last strobe is in cycle T+2**num_qubit. done is in T+2**num_qubit+1. cmd_ready is high again in T+2**num_qubit+2.
- Total: 2**num_qubit+2 cycles per accepted command.
- Bad command: done/err in T+1, cmd_ready in T+2.
- stall is sampled each RUN cycle. A stall cycle suppresses the strobe and freezes the counter. Stall in IDLE/DONE has no effect.
- All outputs are registered. There is no combinational cmd_valid→cmd_ready path.

## Configuration
- BASIS_SEQ_STALL_EN defined: the stall port exists and behaves as above.
- Undefined: no stall port; RUN strobes every cycle and the pass length is fixed.

## Structure
- Package basis_seq_pkg holds the gate-type localparams (GATE_H=0 … GATE_TOFFOLI=5), the FSM state enum, and the function computing list depth from num_qubit.
- Sub-module basis_pass_counter: clear/enable/terminal-count counter, parameterized by num_qubit.

## Test plan
- num_qubit=4, Hadamard, pos=2, ahead=1, reload=1 → exactly 16 ld_basis_index_in pulses in T+1..T+16, done at T+17, rotateLeft strobe never high.
- CNOT, pos=0, pos2=3, reload=0 → 16 rotateLeft_stabilizer_basis2 pulses, qubit_pos2_norm=3 throughout, done at T+17, err=0.
- CNOT, pos=1, pos2=1 → no strobes, done and err at T+1, cmd_ready at T+2. Repeat with gate_type=6 → same response.
- With the macro, stall high in cycles T+5..T+7 → 16 strobes total, done at T+20.
- cmd_valid held through a pass with a second command → second command accepted only at T+18, first command's latched outputs unchanged until then.
- rst asserted at T+8 → strobes/busy drop immediately, no done, cmd_ready=1 after release, next command gives a full 16-strobe pass.

Source files
------------

// File: rtl/basis_seq_pkg.sv
// Shared gate-type codes, FSM state encoding and list-depth helper for the
// basis-index list sequencer.
package basis_seq_pkg;

  localparam logic [2:0] GATE_H       = 3'd0;
  localparam logic [2:0] GATE_PHASE   = 3'd1;
  localparam logic [2:0] GATE_CNOT    = 3'd2;
  localparam logic [2:0] GATE_MEAS    = 3'd3;
  localparam logic [2:0] GATE_CPS     = 3'd4;
  localparam logic [2:0] GATE_TOFFOLI = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  function automatic int unsigned list_depth(input int unsigned nq);
    return 32'd1 << nq;
  endfunction

endpackage

// File: rtl/basis_pass_counter.sv
// Per-pass strobe counter: synchronous clear, count enable, and a terminal
// flag for the last entry of a 2**NUM_QUBIT deep list.
module basis_pass_counter
  import basis_seq_pkg::*;
#(
  parameter int unsigned NUM_QUBIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int unsigned CW = NUM_QUBIT + 1;
  localparam logic [CW-1:0] LAST = CW'(list_depth(NUM_QUBIT) - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/basis_list_sequencer.sv
// Command-driven pass sequencer: one strobe per list entry per accepted gate.
// Optional stall input enabled by defining BASIS_SEQ_STALL_EN.
module basis_list_sequencer
  import basis_seq_pkg::*;
#(
  parameter int unsigned num_qubit = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_gate_type,
  input  logic [31:0] cmd_qubit_pos,
  input  logic [31:0] cmd_qubit_pos2,
  input  logic [31:0] cmd_qubit_pos_ahead,
  input  logic        cmd_reload,
`ifdef BASIS_SEQ_STALL_EN
  input  logic        stall,
`endif
  output logic [2:0]  gate_type_norm,
  output logic [31:0] qubit_pos_norm,
  output logic [31:0] qubit_pos2_norm,
  output logic [31:0] qubit_pos_ahead,
  output logic        ld_basis_index_in,
  output logic        rotateLeft_stabilizer_basis2,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] NQ = 32'(num_qubit);

  seq_state_t r_state, w_state_nx;
  logic       r_strobe, w_strobe_nx;
  logic       r_reload, r_err;
  logic       w_accept, w_bad, w_two_qubit, w_terminal, w_stall;

`ifdef BASIS_SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_two_qubit = (cmd_gate_type == GATE_CNOT) || (cmd_gate_type == GATE_TOFFOLI);
  assign w_bad = (cmd_gate_type > GATE_TOFFOLI) || (cmd_qubit_pos >= NQ) ||
                 (cmd_qubit_pos_ahead >= NQ) ||
                 (w_two_qubit && ((cmd_qubit_pos2 >= NQ) || (cmd_qubit_pos2 == cmd_qubit_pos)));

  basis_pass_counter #(.NUM_QUBIT(num_qubit)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept),
    .i_enable   (r_strobe),
    .o_terminal (w_terminal)
  );

  // Strobe is registered: stall seen in one RUN cycle suppresses the next strobe.
  always_comb begin
    w_state_nx  = r_state;
    w_strobe_nx = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (w_bad) begin
            w_state_nx = ST_DONE;
          end else begin
            w_state_nx  = ST_RUN;
            w_strobe_nx = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (r_strobe && w_terminal) w_state_nx = ST_DONE;
        else                        w_strobe_nx = ~w_stall;
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_strobe        <= 1'b0;
      r_reload        <= 1'b0;
      r_err           <= 1'b0;
      gate_type_norm  <= '0;
      qubit_pos_norm  <= '0;
      qubit_pos2_norm <= '0;
      qubit_pos_ahead <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_strobe <= w_strobe_nx;
      r_err    <= w_accept & w_bad;
      if (w_accept) begin
        r_reload        <= cmd_reload;
        gate_type_norm  <= cmd_gate_type;
        qubit_pos_norm  <= cmd_qubit_pos;
        qubit_pos2_norm <= cmd_qubit_pos2;
        qubit_pos_ahead <= cmd_qubit_pos_ahead;
      end
    end
  end

  assign cmd_ready                    = (r_state == ST_IDLE);
  assign busy                         = (r_state != ST_IDLE);
  assign done                         = (r_state == ST_DONE);
  assign err                          = r_err;
  assign ld_basis_index_in            = r_strobe & r_reload;
  assign rotateLeft_stabilizer_basis2 = r_strobe & ~r_reload;

endmodule

// File: tb/tb_basis_list_sequencer.sv
// Scoreboard bench for basis_list_sequencer (num_qubit=4); stall scenario
// is exercised only when BASIS_SEQ_STALL_EN is defined.
module tb_basis_list_sequencer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_gate_type = '0;
  logic [31:0] cmd_qubit_pos = '0, cmd_qubit_pos2 = '0, cmd_qubit_pos_ahead = '0;
  logic        cmd_reload = 1'b0;
`ifdef BASIS_SEQ_STALL_EN
  logic        stall = 1'b0;
`endif
  logic [2:0]  gate_type_norm;
  logic [31:0] qubit_pos_norm, qubit_pos2_norm, qubit_pos_ahead;
  logic        ld_basis_index_in, rotateLeft_stabilizer_basis2, busy, done, err;

  basis_list_sequencer #(.num_qubit(4)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .cmd_gate_type                (cmd_gate_type),
    .cmd_qubit_pos                (cmd_qubit_pos),
    .cmd_qubit_pos2               (cmd_qubit_pos2),
    .cmd_qubit_pos_ahead          (cmd_qubit_pos_ahead),
    .cmd_reload                   (cmd_reload),
`ifdef BASIS_SEQ_STALL_EN
    .stall                        (stall),
`endif
    .gate_type_norm               (gate_type_norm),
    .qubit_pos_norm               (qubit_pos_norm),
    .qubit_pos2_norm              (qubit_pos2_norm),
    .qubit_pos_ahead              (qubit_pos_ahead),
    .ld_basis_index_in            (ld_basis_index_in),
    .rotateLeft_stabilizer_basis2 (rotateLeft_stabilizer_basis2),
    .busy                         (busy),
    .done                         (done),
    .err                          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  gt;
    logic [31:0] p, p2, pa;
    bit          reload;
    bit          bad;
    int          acc;
    int          extra;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0, n_pass = 0;
  int   n_ld = 0, n_rot = 0;
  bit   post_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
  endtask

  function automatic bit model_bad(input logic [2:0] gt, input logic [31:0] p,
                                   input logic [31:0] p2, input logic [31:0] pa);
    bit two = (gt == 3'd2) || (gt == 3'd5);
    return (gt > 3'd5) || (p >= 32'd4) || (pa >= 32'd4) || (two && ((p2 >= 32'd4) || (p2 == p)));
  endfunction

  function automatic exp_t mk(input logic [2:0] gt, input logic [31:0] p, input logic [31:0] p2,
                              input logic [31:0] pa, input bit rl, input int acc, input int extra);
    exp_t e;
    e.gt = gt; e.p = p; e.p2 = p2; e.pa = pa; e.reload = rl;
    e.bad = model_bad(gt, p, p2, pa); e.acc = acc; e.extra = extra;
    return e;
  endfunction

  // Monitor: per-cycle invariants, strobe tally, pass closure against scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      n_ld = 0; n_rot = 0; post_done = 1'b0;
    end else begin
      exp_t e;
      if (post_done) begin
        chk("ready_after_done", {31'd0, cmd_ready}, 32'd1);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        post_done = 1'b0;
      end
      chk("strobe_exclusive", {31'd0, ld_basis_index_in & rotateLeft_stabilizer_basis2}, 32'd0);
      chk("strobe_needs_busy", {31'd0, (ld_basis_index_in | rotateLeft_stabilizer_basis2) & ~busy}, 32'd0);
      if (busy && sb.size() > 0) begin
        e = sb[0];
        chk("gate_type_norm", {29'd0, gate_type_norm}, {29'd0, e.gt});
        chk("qubit_pos_norm", qubit_pos_norm, e.p);
        chk("qubit_pos2_norm", qubit_pos2_norm, e.p2);
        chk("qubit_pos_ahead", qubit_pos_ahead, e.pa);
        if (ld_basis_index_in) n_ld++;
        if (rotateLeft_stabilizer_basis2) n_rot++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ld_count", n_ld, (!e.bad && e.reload) ? DEPTH : 0);
          chk("rot_count", n_rot, (!e.bad && !e.reload) ? DEPTH : 0);
          chk("err", {31'd0, err}, {31'd0, e.bad});
          chk("done_cycle", cyc - e.acc, e.bad ? 0 : DEPTH + e.extra);
          chk("ready_in_done", {31'd0, cmd_ready}, 32'd0);
        end
        n_ld = 0; n_rot = 0; post_done = 1'b1;
      end else begin
        chk("err_without_done", {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    ok = cmd_ready;
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive(input logic [2:0] gt, input logic [31:0] p, input logic [31:0] p2,
                       input logic [31:0] pa, input bit rl);
    cmd_gate_type = gt; cmd_qubit_pos = p; cmd_qubit_pos2 = p2;
    cmd_qubit_pos_ahead = pa; cmd_reload = rl;
  endtask

  task automatic send_cmd(input logic [2:0] gt, input logic [31:0] p, input logic [31:0] p2,
                          input logic [31:0] pa, input bit rl, input int extra, output int acc);
    bit ok;
    wait_ready(ok);
    acc = cyc + 1;
    if (ok) begin
      drive(gt, p, p2, pa, rl);
      cmd_valid = 1'b1;
      sb.push_back(mk(gt, p, p2, pa, rl, acc, extra));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    int  acc;
    bit  ok;
    #1 fork begin #300000 $display("FAIL global_timeout"); $fatal(1); end join_none

    #22;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_strobes", {30'd0, ld_basis_index_in, rotateLeft_stabilizer_basis2}, 32'd0);
    chk("rst_gate_type", {29'd0, gate_type_norm}, 32'd0);
    chk("rst_pos", qubit_pos_norm | qubit_pos2_norm | qubit_pos_ahead, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    send_cmd(3'd0, 32'd2, 32'd0, 32'd1, 1'b1, 0, acc);   // Hadamard, reload
    send_cmd(3'd2, 32'd0, 32'd3, 32'd2, 1'b0, 0, acc);   // CNOT refresh
    send_cmd(3'd2, 32'd1, 32'd1, 32'd0, 1'b0, 0, acc);   // CNOT control==target
    send_cmd(3'd6, 32'd1, 32'd2, 32'd0, 1'b1, 0, acc);   // illegal type
    send_cmd(3'd1, 32'd4, 32'd0, 32'd0, 1'b1, 0, acc);   // pos out of range
    send_cmd(3'd3, 32'd3, 32'd0, 32'd4, 1'b0, 0, acc);   // ahead out of range
    send_cmd(3'd5, 32'd3, 32'd4, 32'd0, 1'b0, 0, acc);   // Toffoli target out of range
    send_cmd(3'd5, 32'd3, 32'd0, 32'd2, 1'b0, 0, acc);   // Toffoli legal
    send_cmd(3'd4, 32'd3, 32'd3, 32'd3, 1'b1, 0, acc);   // CPS, pos2 ignored
    send_cmd(3'd3, 32'd0, 32'd9, 32'd3, 1'b1, 0, acc);   // Measurement

    // Back-to-back offer: second command must wait for the first pass to close.
    wait_ready(ok);
    if (ok) begin
      acc = cyc + 1;
      drive(3'd1, 32'd3, 32'd2, 32'd1, 1'b1);
      cmd_valid = 1'b1;
      sb.push_back(mk(3'd1, 32'd3, 32'd2, 32'd1, 1'b1, acc, 0));
      @(posedge clk);
      #1 drive(3'd2, 32'd1, 32'd2, 32'd3, 1'b0);
      sb.push_back(mk(3'd2, 32'd1, 32'd2, 32'd3, 1'b0, acc + DEPTH + 2, 0));
      wait_ready(ok);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end

`ifdef BASIS_SEQ_STALL_EN
    send_cmd(3'd0, 32'd1, 32'd0, 32'd0, 1'b0, 3, acc);
    while (cyc < acc + 4) @(posedge clk);
    #1 stall = 1'b1;
    while (cyc < acc + 7) @(posedge clk);
    #1 stall = 1'b0;
`endif

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  gt = 3'($urandom_range(0, 6));
      logic [31:0] p  = 32'($urandom_range(0, 4));
      logic [31:0] p2 = 32'($urandom_range(0, 4));
      logic [31:0] pa = 32'($urandom_range(0, 4));
      send_cmd(gt, p, p2, pa, 1'($urandom_range(0, 1)), 0, acc);
    end

    // Mid-pass reset: abort without done, then a clean full pass.
    send_cmd(3'd5, 32'd2, 32'd1, 32'd3, 1'b1, 0, acc);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_strobes", {30'd0, ld_basis_index_in, rotateLeft_stabilizer_basis2}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_gate_type", {29'd0, gate_type_norm}, 32'd0);
    chk("abort_pos", qubit_pos_norm | qubit_pos2_norm | qubit_pos_ahead, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
    send_cmd(3'd0, 32'd1, 32'd0, 32'd2, 1'b0, 0, acc);

    drain();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
